// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: big-endian byte stream (16-bit word count, then words) -> sequential imem writes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_FIN, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_FIN, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t            r_state, w_state;
  logic [15:0]       r_len, w_len;
  logic [15:0]       r_cnt, w_cnt;
  logic [1:0]        r_idx, w_idx;
  logic              r_in_ready, w_in_ready;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic              r_hold, w_hold;
  logic              r_done, w_done;
  logic              r_error, w_error;
  logic              w_accept;
  logic [15:0]       w_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum, w_csum;
`endif

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_n      = {r_len[15:8], bus.in_byte};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_LEN_HI;
      r_len      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_in_ready <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_len      <= w_len;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_in_ready <= w_in_ready;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_hold     <= w_hold;
      r_done     <= w_done;
      r_error    <= w_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= w_csum;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_in_ready = r_in_ready;
    w_we       = 1'b0;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_hold     = r_hold;
    w_done     = r_done;
    w_error    = r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_csum     = w_accept ? (r_csum ^ bus.in_byte) : r_csum;
`endif

    case (r_state)
      S_LEN_HI: begin
        if (w_accept) begin
          w_len[15:8] = bus.in_byte;
          w_state     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          w_len = w_n;
          if (w_n > DEPTH_W) begin
            w_state    = S_ERR;
            w_in_ready = 1'b0;
            w_error    = 1'b1;
          end else if (w_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state    = S_CSUM;
`else
            w_state    = S_FIN;
            w_in_ready = 1'b0;
`endif
          end else begin
            w_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_wdata = {r_wdata[23:0], bus.in_byte};
          w_idx   = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state    = S_WRITE;
            w_in_ready = 1'b0;
            w_we       = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // Address/count advance after the strobe so mem_addr is stable during it.
        w_addr = r_addr + ADDR_W'(4);
        w_cnt  = r_cnt + 16'd1;
        if (w_cnt == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state    = S_CSUM;
          w_in_ready = 1'b1;
`else
          w_state    = S_FIN;
`endif
        end else begin
          w_state    = S_DATA;
          w_in_ready = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_in_ready = 1'b0;
          if (bus.in_byte == r_csum) begin
            w_state = S_FIN;
          end else begin
            w_state = S_ERR;
            w_error = 1'b1;
          end
        end
      end
`endif
      S_FIN: begin
        w_state = S_DONE;
        w_done  = 1'b1;
        w_hold  = 1'b0;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_hold  = r_hold;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule
